axi4_lite_master: RTL and testbench
===================================

# axi4_lite_master

AXI4-Lite initiator that converts single-beat commands from a simple valid/ready command port into AXI4-Lite write and read transactions. It issues one outstanding transaction at a time. It returns read data and the response code on a one-cycle response strobe. It drives our axi4_lite_slave register block in simulation and on the FPGA, and is the bus-side front end for any local controller or test sequencer.

## Interface
- ADDRESS, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- M_AWADDR, M_AWVALID  out; M_AWREADY  in.  Write address channel.
- M_WDATA, M_WSTRB, M_WVALID  out; M_WREADY  in.  Write data channel.
- M_BRESP (2), M_BVALID  in; M_BREADY  out.  Write response channel.
- M_ARADDR, M_ARVALID  out; M_ARREADY  in.  Read address channel.
- M_RDATA, M_RRESP (2), M_RVALID  in; M_RREADY  out.  Read data channel.

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA.
- IDLE: cmd_ready = 1. On cmd_valid, latch addr, wdata and wstrb. Go to WRITE if cmd_write = 1, else RADDR.
- WRITE: M_AWVALID and M_WVALID both assert on entry.
  - Each VALID drops independently after its own handshake (VALID && READY at the clock edge). Track this with flags aw_done and w_done.
  - Leave WRITE when both handshakes are complete, whether they occur in the same cycle or in different cycles.
  - Never deassert a VALID before its handshake. Address, data and strobe are stable while VALID is high.
- WRESP: M_BREADY = 1. On M_BVALID, capture M_BRESP into rsp_resp, set rsp_rdata = 0, pulse rsp_valid, go to IDLE.
- RADDR: M_ARVALID = 1 until M_ARREADY, then go to RDATA.
- RDATA: M_RREADY = 1. On M_RVALID, capture M_RDATA and M_RRESP, pulse rsp_valid, go to IDLE.
- Response codes are passed through unmodified (OKAY, EXOKAY, SLVERR, DECERR). The master does not retry.
- rsp_rdata and rsp_resp hold their values until the next completion.
- Address and data outputs hold the last latched command while idle.

## Timing
- Reset: state = IDLE. All VALID and READY outputs = 0, rsp_valid = 0, cmd_ready = 1. All address, data, strobe, rsp_rdata and rsp_resp outputs = 0.
- All AXI outputs and rsp_* outputs are registered. cmd_ready is decoded from state.
- Command accepted at edge N: AWVALID/WVALID or ARVALID are high in cycle N+1.
- B or R handshake at edge M: rsp_valid is high in cycle M+1 only. The state is IDLE in that same cycle, so a new command can be accepted at edge M+1.
- Against the team slave (READY one cycle after VALID, response one cycle after that):
  - Write: cmd accept to rsp_valid = 4 cycles.
  - Read: cmd accept to rsp_valid = 4 cycles.
- Back-to-back commands: at most one transaction is outstanding; no pipelining.
- Reset mid-transaction: at the first edge with ARESETN = 0, all VALID and READY outputs drop and the state returns to IDLE. No rsp_valid is produced for the aborted transaction.
- cmd_valid while not in IDLE is ignored; the command is not latched.

## Structure
- Shared package axi4_lite_pkg holds:
  - the resp_t enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11;
  - the master state typedef;
  - the default width constants.
- The axi4_lite_slave imports the same resp_t.
- Single module; no sub-module is needed.

## Test plan
- Write 0xDEADBEEF, strobe 0xF, to addr 5 through the team slave → one AW and one W handshake, BRESP 00, rsp_valid for exactly 1 cycle. A following read of addr 5 returns rsp_rdata 0xDEADBEEF, rsp_resp 00.
- AWREADY 3 cycles before WREADY (responder model) → AWVALID drops after its handshake, WVALID stays high until WREADY, exactly one BREADY phase, one rsp_valid.
- Responder returns RRESP 2'b10 with RDATA 0x12345678 → rsp_resp 10, rsp_rdata 0x12345678.
- ARREADY held low for 20 cycles → ARVALID and ARADDR are stable throughout, cmd_ready stays 0, and cmd_valid pulses are ignored.
- ARESETN low while in WRESP → on the next edge all VALID/READY outputs are 0, the state is IDLE, and no rsp_valid appears.
- Ten back-to-back alternating write/read commands to addrs 0–9 → each read returns the data just written, and every rsp_valid is a single-cycle pulse.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and default widths.
// Both the master and the axi4_lite_slave register block import this package.
package axi4_lite_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } mst_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single commands from a valid/ready command port into one
// outstanding AXI4-Lite write or read, returning data and response on a one-cycle strobe.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS    = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    // Command port: a command transfers on any rising edge with cmd_valid && cmd_ready.
    // cmd_ready is high only in IDLE; cmd_valid seen in other states is ignored.
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDRESS-1:0]      M_AWADDR,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [ADDRESS-1:0]      M_ARADDR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    output mst_state_t              dbg_state
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    mst_state_t              state_q, state_d;
    logic [ADDRESS-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    resp_t                   rsp_resp_q, rsp_resp_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_fin, w_fin;

    assign aw_hs  = awvalid_q && M_AWREADY;
    assign w_hs   = wvalid_q && M_WREADY;
    assign b_hs   = bready_q && M_BVALID;
    assign ar_hs  = arvalid_q && M_ARREADY;
    assign r_hs   = rready_q && M_RVALID;
    // A channel counts as finished if it completed earlier or completes on this edge.
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = cmd_write ? WRITE : RADDR;
            WRITE:   if (aw_fin && w_fin) state_d = WRESP;
            WRESP:   if (b_hs) state_d = IDLE;
            RADDR:   if (ar_hs) state_d = RDATA;
            RDATA:   if (r_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) bready_d = 1'b1;
            end
            WRESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = resp_t'(M_BRESP);
                end
            end
            RADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_RDATA;
                    rsp_resp_d  = resp_t'(M_RRESP);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign M_AWADDR  = addr_q;
    assign M_ARADDR  = addr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: configurable AXI4-Lite responder with a small memory,
// response scoreboard with latency tracking, and channel stability monitoring.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int RW = 34;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AWADDR;
    logic        M_AWVALID;
    logic        M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WVALID;
    logic        M_WREADY;
    logic [1:0]  M_BRESP;
    logic        M_BVALID;
    logic        M_BREADY;
    logic [31:0] M_ARADDR;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RVALID;
    logic        M_RREADY;
    mst_state_t  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .dbg_state(dbg_state)
    );

    // Responder: READY one cycle after VALID (plus optional delay), response one cycle later.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_cnt, w_cnt, ar_cnt;
    bit          b_hold = 1'b0;
    bit          force_r = 1'b0;
    logic [1:0]  force_rresp = 2'b00;
    logic [31:0] force_rdata = '0;
    logic [1:0]  force_bresp = 2'b00;
    bit          got_aw, got_w;
    logic [31:0] mem [0:15];

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    always @(posedge ACLK) begin : responder
        bit ga, gw;
        logic [31:0] nw;
        if (!ARESETN) begin
            M_AWREADY <= 1'b0; M_WREADY <= 1'b0; M_ARREADY <= 1'b0;
            M_BVALID <= 1'b0; M_BRESP <= 2'b00;
            M_RVALID <= 1'b0; M_RRESP <= 2'b00; M_RDATA <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
        end else begin
            if (M_AWVALID && M_AWREADY) begin
                M_AWREADY <= 1'b0; aw_cnt <= 0;
            end else if (M_AWVALID) begin
                if (aw_cnt >= aw_delay) M_AWREADY <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (M_WVALID && M_WREADY) begin
                M_WREADY <= 1'b0; w_cnt <= 0;
            end else if (M_WVALID) begin
                if (w_cnt >= w_delay) M_WREADY <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            ga = got_aw || (M_AWVALID && M_AWREADY);
            gw = got_w || (M_WVALID && M_WREADY);
            if (M_BVALID && M_BREADY) M_BVALID <= 1'b0;
            if (ga && gw && !M_BVALID && !b_hold) begin
                nw = mem[M_AWADDR[3:0]];
                for (int b = 0; b < 4; b++) if (M_WSTRB[b]) nw[8*b +: 8] = M_WDATA[8*b +: 8];
                mem[M_AWADDR[3:0]] <= nw;
                M_BVALID <= 1'b1;
                M_BRESP <= force_bresp;
                got_aw <= 1'b0;
                got_w <= 1'b0;
            end else begin
                got_aw <= ga;
                got_w <= gw;
            end
            if (M_RVALID && M_RREADY) M_RVALID <= 1'b0;
            if (M_ARVALID && M_ARREADY) begin
                M_ARREADY <= 1'b0; ar_cnt <= 0;
                M_RVALID <= 1'b1;
                M_RDATA <= force_r ? force_rdata : mem[M_ARADDR[3:0]];
                M_RRESP <= force_r ? force_rresp : 2'b00;
            end else if (M_ARVALID) begin
                if (ar_cnt >= ar_delay) M_ARREADY <= 1'b1; else ar_cnt <= ar_cnt + 1;
            end
        end
    end

    int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
    always @(posedge ACLK) if (ARESETN) begin
        if (M_AWVALID && M_AWREADY) aw_hs_n <= aw_hs_n + 1;
        if (M_WVALID && M_WREADY)   w_hs_n  <= w_hs_n + 1;
        if (M_BVALID && M_BREADY)   b_hs_n  <= b_hs_n + 1;
        if (M_ARVALID && M_ARREADY) ar_hs_n <= ar_hs_n + 1;
        if (M_RVALID && M_RREADY)   r_hs_n  <= r_hs_n + 1;
    end

    // A VALID not yet accepted must stay high with unchanged payload.
    logic        p_rst = 1'b0;
    logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    always @(negedge ACLK) begin
        if (ARESETN && p_rst) begin
            if (p_awv && !p_awr) begin
                checks++;
                if (M_AWVALID !== 1'b1 || M_AWADDR !== p_awaddr) begin
                    errors++;
                    $display("FAIL aw_stable: AWVALID=%b AWADDR=%h, required 1 / %h", M_AWVALID, M_AWADDR, p_awaddr);
                end
            end
            if (p_wv && !p_wr) begin
                checks++;
                if (M_WVALID !== 1'b1 || M_WDATA !== p_wdata || M_WSTRB !== p_wstrb) begin
                    errors++;
                    $display("FAIL w_stable: WVALID=%b WDATA=%h WSTRB=%h, required 1 / %h / %h", M_WVALID, M_WDATA, M_WSTRB, p_wdata, p_wstrb);
                end
            end
            if (p_arv && !p_arr) begin
                checks++;
                if (M_ARVALID !== 1'b1 || M_ARADDR !== p_araddr) begin
                    errors++;
                    $display("FAIL ar_stable: ARVALID=%b ARADDR=%h, required 1 / %h", M_ARVALID, M_ARADDR, p_araddr);
                end
            end
        end
        p_rst = ARESETN;
        p_awv = M_AWVALID; p_awr = M_AWREADY; p_awaddr = M_AWADDR;
        p_wv = M_WVALID; p_wr = M_WREADY; p_wdata = M_WDATA; p_wstrb = M_WSTRB;
        p_arv = M_ARVALID; p_arr = M_ARREADY; p_araddr = M_ARADDR;
    end

    // Scoreboard: {resp, rdata} plus the cycle the response must appear in (0 = unchecked).
    logic [RW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    bit            prev_rsp = 1'b0;
    always @(negedge ACLK) begin : rsp_monitor
        logic [RW-1:0] e;
        int c;
        if (rsp_valid === 1'b1) begin
            checks++;
            if (prev_rsp) begin
                errors++;
                $display("FAIL rsp_pulse: rsp_valid high for consecutive cycles at cycle %0d, required single-cycle pulse", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=1 resp=%b rdata=%h at cycle %0d, required no response", rsp_resp, rsp_rdata, cyc);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                if ({rsp_resp, rsp_rdata} !== e) begin
                    errors++;
                    $display("FAIL rsp_data: resp=%b rdata=%h, required resp=%b rdata=%h", rsp_resp, rsp_rdata, e[33:32], e[31:0]);
                end
                if (c != 0) begin
                    checks++;
                    if (cyc != c) begin
                        errors++;
                        $display("FAIL rsp_latency: rsp_valid at cycle %0d, required cycle %0d", cyc, c);
                    end
                end
            end
        end
        prev_rsp = (rsp_valid === 1'b1);
    end

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [RW-1:0] exp, input bit chk_lat);
        int n;
        n = 0;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        exp_cyc_q.push_back(chk_lat ? cyc + 4 : 0);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cmd_ready !== 1'b1) && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding, cmd_ready=%b, required 0 / 1", exp_q.size(), cmd_ready);
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: aw/w/b/ar/r/rsp=%b, required 000000",
                     {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid});
        end
        checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: cmd_ready=%b state=%0d, required 1 / %0d", cmd_ready, dbg_state, IDLE);
        end
        checks++;
        if ({M_AWADDR, M_ARADDR, M_WDATA, M_WSTRB, rsp_rdata, rsp_resp} !== '0) begin
            errors++;
            $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%b, required all 0",
                     M_AWADDR, M_ARADDR, M_WDATA, M_WSTRB, rsp_rdata, rsp_resp);
        end
        ARESETN = 1'b1;
    endtask

    task automatic test_write_read();
        int a0, w0, b0;
        a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        send_cmd(1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, {OKAY, 32'h0}, 1'b1);
        wait_idle();
        checks++;
        if (aw_hs_n - a0 != 1 || w_hs_n - w0 != 1 || b_hs_n - b0 != 1) begin
            errors++;
            $display("FAIL write_handshakes: aw=%0d w=%0d b=%0d, required 1 each", aw_hs_n - a0, w_hs_n - w0, b_hs_n - b0);
        end
        send_cmd(1'b0, 32'd5, 32'h0, 4'h0, {OKAY, 32'hDEAD_BEEF}, 1'b1);
        wait_idle();
    endtask

    task automatic test_skewed_write();
        int a0, w0, b0, n;
        bit split;
        w_delay = 3;
        a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        split = 1'b0;
        n = 0;
        send_cmd(1'b1, 32'd6, 32'hA5A5_0F0F, 4'b0011, {OKAY, 32'h0}, 1'b0);
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge ACLK);
            if (M_AWVALID === 1'b0 && M_WVALID === 1'b1 && dbg_state === WRITE) split = 1'b1;
            n++;
        end
        wait_idle();
        checks++;
        if (!split) begin
            errors++;
            $display("FAIL skew_split: AWVALID-low-while-WVALID-high seen=%0d, required 1", split);
        end
        checks++;
        if (aw_hs_n - a0 != 1 || w_hs_n - w0 != 1 || b_hs_n - b0 != 1) begin
            errors++;
            $display("FAIL skew_handshakes: aw=%0d w=%0d b=%0d, required 1 each", aw_hs_n - a0, w_hs_n - w0, b_hs_n - b0);
        end
        w_delay = 0;
        send_cmd(1'b0, 32'd6, 32'h0, 4'h0, {OKAY, 32'h0000_0F0F}, 1'b1);
        wait_idle();
    endtask

    task automatic test_error_resp();
        force_r = 1'b1; force_rresp = SLVERR; force_rdata = 32'h1234_5678;
        send_cmd(1'b0, 32'd3, 32'h0, 4'h0, {SLVERR, 32'h1234_5678}, 1'b1);
        wait_idle();
        force_r = 1'b0;
        force_bresp = DECERR;
        send_cmd(1'b1, 32'd7, 32'h5555_AAAA, 4'hF, {DECERR, 32'h0}, 1'b1);
        wait_idle();
        force_bresp = OKAY;
    endtask

    task automatic test_ar_stall();
        int a0;
        send_cmd(1'b1, 32'd9, 32'hCAFE_F00D, 4'hF, {OKAY, 32'h0}, 1'b1);
        wait_idle();
        ar_delay = 20;
        a0 = aw_hs_n;
        send_cmd(1'b0, 32'd9, 32'h0, 4'h0, {OKAY, 32'hCAFE_F00D}, 1'b0);
        for (int i = 0; i < 18; i++) begin
            @(negedge ACLK);
            checks++;
            if (cmd_ready !== 1'b0 || M_ARVALID !== 1'b1 || M_ARADDR !== 32'd9) begin
                errors++;
                $display("FAIL ar_stall: cycle %0d cmd_ready=%b ARVALID=%b ARADDR=%h, required 0 / 1 / 00000009",
                         i, cmd_ready, M_ARVALID, M_ARADDR);
            end
            cmd_valid = (i % 2 == 0); cmd_write = 1'b1; cmd_addr = 32'd15; cmd_wdata = 32'hBAD0_BAD0; cmd_wstrb = 4'hF;
        end
        @(negedge ACLK);
        cmd_valid = 1'b0;
        wait_idle();
        ar_delay = 0;
        checks++;
        if (aw_hs_n != a0 || mem[15] !== 32'h0) begin
            errors++;
            $display("FAIL ignored_cmd: extra AW handshakes=%0d mem[15]=%h, required 0 / 00000000", aw_hs_n - a0, mem[15]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        b_hold = 1'b1;
        n = 0;
        send_cmd(1'b1, 32'd2, 32'h1111_2222, 4'hF, {OKAY, 32'h0}, 1'b0);
        while (dbg_state !== WRESP && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (dbg_state !== WRESP || M_BREADY !== 1'b1) begin
            errors++;
            $display("FAIL wresp_reach: state=%0d BREADY=%b, required %0d / 1", dbg_state, M_BREADY, WRESP);
        end
        @(negedge ACLK);
        ARESETN = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        @(posedge ACLK);
        #1;
        checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid} !== 6'b0 || cmd_ready !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset: aw/w/b/ar/r/rsp=%b cmd_ready=%b state=%0d, required 000000 / 1 / %0d",
                     {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, cmd_ready, dbg_state, IDLE);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        b_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_rsp: rsp_valid=%b %0d cycles after reset, required 0", rsp_valid, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 10; i++) begin
            d = $urandom_range(32'hFFFF_FFFF, 0);
            send_cmd(1'b1, i, d, 4'hF, {OKAY, 32'h0}, 1'b1);
            send_cmd(1'b0, i, 32'h0, 4'h0, {OKAY, d}, 1'b1);
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_skewed_write();
        test_error_resp();
        test_ar_stall();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
